life_engine_param: RTL and testbench
====================================

// Module: life_engine_param
// PURPOSE
//  Parametrised Game-of-Life datapath: ROWS x COLS grid, selectable dead-edge or toroidal boundary.
//  Computes one generation row-serially (one row per clock) into a shadow buffer, then commits atomically.
//  Adds per-generation handshake, generation counter and stable/extinct detection.
//  Sits under the top-level FSM, which drives state/btn/step; grid feeds the display driver.
// PARAMETERS
//  ROWS   8   grid rows (>=3)
//  COLS   8   grid columns (>=3)
//  GEN_W  16  generation counter width
// PORTS
//  clka       in   1          single clock; all logic on posedge clka
//  stop       in   1          reset: synchronous, active-high
//  state      in   2          00 IDLE, 01 PROGRAM, 10 RUN, 11 HOLD (encodings from gol_pkg)
//  btn0       in   1          PROGRAM: write 0 at prog_idx (1-cycle pulse, pre-debounced)
//  btn1       in   1          PROGRAM: write 1 at prog_idx (1-cycle pulse)
//  step       in   1          RUN: request one generation; ignored while busy
//  wrap_mode  in   1          0 = cells outside grid dead; 1 = toroidal wrap
//  grid       out  ROWS*COLS  current generation; bit r*COLS+c, bit 0 = top-left
//  prog_idx   out  $clog2(ROWS*COLS)  next cell PROGRAM writes
//  busy       out  1          generation in progress
//  gen_done   out  1          1-cycle pulse on commit cycle
//  gen_count  out  GEN_W      generations committed since last clear; saturates at all-ones
//  stable     out  1          last commit produced grid identical to previous
//  extinct    out  1          last commit produced all-zero grid
// BEHAVIOUR
//  Reset (stop=1): grid, shadow, prog_idx, gen_count, busy, gen_done, stable, extinct, row ctr all 0. Overrides everything.
//  IDLE: grid, prog_idx, gen_count, stable, extinct cleared each cycle; busy forced 0.
//  PROGRAM: btn1&!btn0 -> grid[prog_idx]<=1, prog_idx++; btn0&!btn1 -> grid[prog_idx]<=0, prog_idx++;
//   both/neither -> no change. prog_idx wraps N-1 -> 0 (N=ROWS*COLS). grid visible next cycle.
//  RUN engine FSM: S_IDLE -> S_ROW -> S_COMMIT -> S_IDLE.
//   S_IDLE: step=1 -> row ctr<=0, busy<=1, S_ROW.
//   S_ROW: compute next state of all COLS cells of row ctr from grid rows ctr-1, ctr, ctr+1 into shadow;
//    ctr==ROWS-1 -> S_COMMIT else ctr++. grid unchanged during S_ROW.
//   S_COMMIT: grid<=shadow; gen_done=1; busy<=0; gen_count++ (saturating);
//    stable<=(shadow==grid); extinct<=(shadow==0); -> S_IDLE.
//  Latency: step at cycle t -> grid updated at edge t+ROWS+1; gen_done high in cycle t+ROWS+1; busy high cycles t+1..t+ROWS+1.
//  Back-to-back: step in commit cycle ignored; step accepted from next cycle -> max rate 1 gen / ROWS+2 cycles.
//  Neighbour count: 4-bit sum of 8 neighbours, 0..8. Rule: alive&&(n==2||n==3) -> 1; !alive&&n==3 -> 1; else 0.
//  Boundary: wrap_mode=0 -> out-of-range neighbour = 0. wrap_mode=1 -> row/col index modulo ROWS/COLS.
//   wrap_mode sampled per row; changing it mid-generation is legal but mixes modes (not a fault).
//  HOLD: engine paused; grid, counters, flags held; a generation in progress freezes and resumes on return to RUN.
//  Leaving RUN/HOLD to IDLE or PROGRAM while busy: generation aborted, shadow discarded, grid unchanged, busy<=0, no gen_done.
//  stable/extinct held until next commit or clear.
// STRUCTURE
//  gol_pkg: state encodings (ST_IDLE/ST_PROGRAM/ST_RUN/ST_HOLD), engine state enum, function cell_next(n[3:0], alive).
//  Sub-module life_row_next #(COLS): combinational; inputs above/cur/below rows [COLS-1:0] + wrap_mode,
//   output next row [COLS-1:0]. Parent selects rows (with wrap/zero at row edges), owns FSM, shadow, counters.
// TESTING
//  8x8, wrap=0, blinker bits 27,28,29; step -> grid bits 20,28,36 only, gen_done at cycle t+9, gen_count=1, stable=0.
//  8x8, 2x2 block at bits 0,1,8,9, wrap=0; step -> grid unchanged, stable=1, extinct=0.
//  8x8, cells 0,7,56 alive: wrap=1 -> cell 63 born (3 neighbours); wrap=0 -> all die, extinct=1.
//  PROGRAM: 64 btn1 pulses -> grid all ones, prog_idx wraps to 0; btn0+btn1 same cycle -> no change, idx unchanged.
//  stop asserted at busy cycle 4 -> next cycle all outputs 0; state->PROGRAM while busy -> grid unchanged, no gen_done.
//  GEN_W=2: 5 steps on block -> gen_count saturates at 3; ROWS=5,COLS=6 glider wrap=1 -> returns to start after 4*lcm-shift gens.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared encodings for the Game-of-Life engine: top-level mode codes,
// engine sequencer states and the per-cell birth/survival rule.
package gol_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PROGRAM = 2'b01;
    localparam logic [1:0] ST_RUN     = 2'b10;
    localparam logic [1:0] ST_HOLD    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROW    = 2'd1,
        S_COMMIT = 2'd2
    } eng_state_e;

    // n is the live-neighbour count (0..8) of a cell whose current value is alive.
    function automatic logic cell_next(input logic [3:0] n, input logic alive);
        return alive ? ((n == 4'd2) || (n == 4'd3)) : (n == 4'd3);
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation of one grid row, given the rows above and below.
// Column edges are either dead or wrapped; row-edge handling belongs to the caller.
module life_row_next
    import gol_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic [COLS-1:0] above_i,
    input  logic [COLS-1:0] cur_i,
    input  logic [COLS-1:0] below_i,
    input  logic            wrap_i,
    output logic [COLS-1:0] next_o
);

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        localparam int CL = (c == 0) ? COLS - 1 : c - 1;
        localparam int CR = (c == COLS - 1) ? 0 : c + 1;

        logic       l_ok;
        logic       r_ok;
        logic [3:0] n;

        // Wrapped column neighbours only count in toroidal mode.
        assign l_ok = (c != 0) || wrap_i;
        assign r_ok = (c != COLS - 1) || wrap_i;

        assign n = 4'(above_i[CL] & l_ok) + 4'(above_i[c]) + 4'(above_i[CR] & r_ok)
                 + 4'(cur_i[CL] & l_ok)                     + 4'(cur_i[CR] & r_ok)
                 + 4'(below_i[CL] & l_ok) + 4'(below_i[c]) + 4'(below_i[CR] & r_ok);

        assign next_o[c] = cell_next(n, cur_i[c]);
    end

endmodule

// File: rtl/life_engine_param.sv
// ROWS x COLS Game-of-Life engine: programmable grid, row-serial generation into a
// shadow buffer with an atomic commit, generation counter and stable/extinct flags.
module life_engine_param
    import gol_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                          clka,
    input  logic                          stop,
    input  logic [1:0]                    state,
    input  logic                          btn0,
    input  logic                          btn1,
    input  logic                          step,
    input  logic                          wrap_mode,
    output logic [ROWS*COLS-1:0]          grid,
    output logic [$clog2(ROWS*COLS)-1:0]  prog_idx,
    output logic                          busy,
    output logic                          gen_done,
    output logic [GEN_W-1:0]              gen_count,
    output logic                          stable,
    output logic                          extinct
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int RW    = $clog2(ROWS);

    logic [N-1:0]     grid_q;
    logic [N-1:0]     shadow_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [RW-1:0]    row_q;
    logic [GEN_W-1:0] gen_q;
    eng_state_e       eng_q;
    logic             busy_q;
    logic             done_q;
    logic             stable_q;
    logic             extinct_q;

    int               row_i;
    logic [COLS-1:0]  above;
    logic [COLS-1:0]  cur;
    logic [COLS-1:0]  below;
    logic [COLS-1:0]  next_row;

    // Neighbour rows of the row being computed; off-grid rows are dead unless wrapping.
    always_comb begin
        row_i = int'(row_q);
        cur   = grid_q[row_i*COLS +: COLS];
        above = '0;
        below = '0;
        if (row_i > 0)
            above = grid_q[(row_i-1)*COLS +: COLS];
        else if (wrap_mode)
            above = grid_q[(ROWS-1)*COLS +: COLS];
        if (row_i < ROWS - 1)
            below = grid_q[(row_i+1)*COLS +: COLS];
        else if (wrap_mode)
            below = grid_q[0 +: COLS];
    end

    life_row_next #(.COLS(COLS)) u_row_next (
        .above_i (above),
        .cur_i   (cur),
        .below_i (below),
        .wrap_i  (wrap_mode),
        .next_o  (next_row)
    );

    assign idx_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clka) begin
        if (stop) begin
            grid_q    <= '0;
            shadow_q  <= '0;
            idx_q     <= '0;
            row_q     <= '0;
            gen_q     <= '0;
            eng_q     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    grid_q    <= '0;
                    idx_q     <= '0;
                    gen_q     <= '0;
                    stable_q  <= 1'b0;
                    extinct_q <= 1'b0;
                    eng_q     <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
                ST_PROGRAM: begin
                    // Any in-flight generation is abandoned; the shadow is simply never committed.
                    eng_q  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (btn1 && !btn0) begin
                        grid_q[idx_q] <= 1'b1;
                        idx_q         <= idx_d;
                    end else if (btn0 && !btn1) begin
                        grid_q[idx_q] <= 1'b0;
                        idx_q         <= idx_d;
                    end
                end
                ST_RUN: begin
                    case (eng_q)
                        S_IDLE: begin
                            done_q <= 1'b0;
                            if (step) begin
                                row_q  <= '0;
                                busy_q <= 1'b1;
                                eng_q  <= S_ROW;
                            end
                        end
                        S_ROW: begin
                            shadow_q[row_i*COLS +: COLS] <= next_row;
                            if (row_q == RW'(ROWS - 1)) begin
                                eng_q  <= S_COMMIT;
                                done_q <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end
                        S_COMMIT: begin
                            grid_q    <= shadow_q;
                            done_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            stable_q  <= (shadow_q == grid_q);
                            extinct_q <= (shadow_q == '0);
                            if (gen_q != {GEN_W{1'b1}})
                                gen_q <= gen_q + 1'b1;
                            eng_q     <= S_IDLE;
                        end
                        default: begin
                            eng_q  <= S_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b0;
                        end
                    endcase
                end
                ST_HOLD: begin
                    // Everything freezes, including a partially built shadow.
                end
                default: ;
            endcase
        end
    end

    assign grid      = grid_q;
    assign prog_idx  = idx_q;
    assign busy      = busy_q;
    assign gen_done  = done_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine_param.sv
// Directed and randomised checks of life_engine_param: reset, programming, generation
// results against a software Life model, timing, hold/abort/stop, saturation and a torus glider.
module tb_life_engine_param;
    import gol_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        stop;
    logic [1:0]  state;
    logic        btn0, btn1, step, wrap_mode;
    logic [63:0] grid;
    logic [5:0]  prog_idx;
    logic        busy, gen_done, stable, extinct;
    logic [15:0] gen_count;

    logic [63:0] g2_grid;
    logic [5:0]  g2_idx;
    logic        g2_busy, g2_done, g2_stable, g2_ext;
    logic [1:0]  g2_cnt;

    logic [1:0]  s5_state;
    logic        s5_b0, s5_b1, s5_step;
    logic [29:0] grid5;
    logic [4:0]  idx5;
    logic        busy5, done5, stable5, ext5;
    logic [15:0] cnt5;

    life_engine_param dut (
        .clka(clka), .stop(stop), .state(state), .btn0(btn0), .btn1(btn1), .step(step),
        .wrap_mode(wrap_mode), .grid(grid), .prog_idx(prog_idx), .busy(busy),
        .gen_done(gen_done), .gen_count(gen_count), .stable(stable), .extinct(extinct)
    );

    life_engine_param #(.GEN_W(2)) dut_g2 (
        .clka(clka), .stop(stop), .state(state), .btn0(btn0), .btn1(btn1), .step(step),
        .wrap_mode(wrap_mode), .grid(g2_grid), .prog_idx(g2_idx), .busy(g2_busy),
        .gen_done(g2_done), .gen_count(g2_cnt), .stable(g2_stable), .extinct(g2_ext)
    );

    life_engine_param #(.ROWS(5), .COLS(6)) dut5 (
        .clka(clka), .stop(stop), .state(s5_state), .btn0(s5_b0), .btn1(s5_b1), .step(s5_step),
        .wrap_mode(1'b1), .grid(grid5), .prog_idx(idx5), .busy(busy5),
        .gen_done(done5), .gen_count(cnt5), .stable(stable5), .extinct(ext5)
    );

    // ---------------- scoreboard state ----------------
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_g;
    int          exp_gen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Independent reference: plain 8x8 Life step.
    function automatic logic [63:0] life_model(input logic [63:0] g, input logic wrap);
        logic [63:0] nx;
        int n, rr, cc;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(g[rr*8 + cc]);
                    end
                end
                nx[r*8 + c] = g[r*8 + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nx;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic program_grid(input logic [63:0] g);
        state = ST_IDLE;
        btn0  = 1'b0;
        btn1  = 1'b0;
        tick();
        state = ST_PROGRAM;
        for (int i = 0; i < 64; i++) begin
            btn1 = g[i];
            btn0 = ~g[i];
            tick();
        end
        btn0    = 1'b0;
        btn1    = 1'b0;
        model_g = g;
        exp_gen = 0;
        check("prog_grid", grid, g);
        check("prog_idx", 64'(prog_idx), 64'd0);
    endtask

    task automatic run_gen(input logic wrap, input string tag);
        logic [63:0] exp;
        int          cnt;
        state     = ST_RUN;
        wrap_mode = wrap;
        exp_q.push_back(life_model(model_g, wrap));
        step = 1'b1;
        tick();
        step = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        cnt = 0;
        while (!gen_done && cnt < 40) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'd8);
        check({tag, "_grid_pre"}, grid, model_g);
        tick();
        exp = exp_q.pop_front();
        check({tag, "_grid"}, grid, exp);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_done_end"}, 64'(gen_done), 64'd0);
        if (exp_gen < 65535) exp_gen++;
        check({tag, "_count"}, 64'(gen_count), 64'(exp_gen));
        check({tag, "_stable"}, 64'(stable), 64'(exp == model_g));
        check({tag, "_extinct"}, 64'(extinct), 64'(exp == 64'd0));
        model_g = exp;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] rg;
        logic [29:0] g0, g4;
        int          cnt, seen, lat_bad;

        stop = 1'b1; state = ST_IDLE; btn0 = 1'b0; btn1 = 1'b0; step = 1'b0; wrap_mode = 1'b0;
        s5_state = ST_IDLE; s5_b0 = 1'b0; s5_b1 = 1'b0; s5_step = 1'b0;
        model_g = '0; exp_gen = 0;
        tick();
        tick();
        check("rst_grid", grid, 64'd0);
        check("rst_misc", 64'({prog_idx, busy, gen_done, gen_count, stable, extinct}), 64'd0);
        check("rst_g2", 64'({g2_grid != 64'd0, g2_idx, g2_busy, g2_done, g2_cnt, g2_stable, g2_ext}), 64'd0);
        check("rst_g5", 64'({grid5 != 30'd0, idx5, busy5, done5, cnt5, stable5, ext5}), 64'd0);
        stop = 1'b0;

        // Blinker oscillates with period 2.
        program_grid(64'h0000_0000_3800_0000);
        run_gen(1'b0, "blinker1");
        check("blinker_vert", grid, 64'h0000_0010_1010_0000);
        run_gen(1'b0, "blinker2");

        // Block still life.
        program_grid(64'h0000_0000_0000_0303);
        run_gen(1'b0, "block");
        check("block_stable", 64'(stable), 64'd1);

        // Three corners: torus completes a block, dead edges kill everything.
        program_grid(64'h0100_0000_0000_0081);
        run_gen(1'b1, "corner_wrap");
        check("corner_wrap_grid", grid, 64'h8100_0000_0000_0081);
        program_grid(64'h0100_0000_0000_0081);
        run_gen(1'b0, "corner_dead");
        check("corner_dead_ext", 64'(extinct), 64'd1);

        // Random soups, several generations each.
        for (int k = 0; k < 4; k++) begin
            rg = {$urandom(), $urandom()};
            program_grid(rg);
            for (int j = 0; j < 3; j++)
                run_gen(1'(($urandom_range(0, 1))), "random");
        end

        // Programming: fill, wrap of index, conflicting buttons.
        state = ST_IDLE; tick();
        state = ST_PROGRAM;
        for (int i = 0; i < 64; i++) begin
            btn1 = 1'b1; tick();
            btn1 = 1'b0; tick();
        end
        check("fill_grid", grid, 64'hFFFF_FFFF_FFFF_FFFF);
        check("fill_idx", 64'(prog_idx), 64'd0);
        btn0 = 1'b1; tick(); btn0 = 1'b0;
        check("clear0_grid", grid, 64'hFFFF_FFFF_FFFF_FFFE);
        check("clear0_idx", 64'(prog_idx), 64'd1);
        btn0 = 1'b1; btn1 = 1'b1; tick(); btn0 = 1'b0; btn1 = 1'b0;
        check("both_grid", grid, 64'hFFFF_FFFF_FFFF_FFFE);
        check("both_idx", 64'(prog_idx), 64'd1);

        // Stop in the fourth busy cycle clears every output.
        program_grid(64'h0000_0000_3800_0000);
        run_gen(1'b0, "pre_stop");
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick(); tick();
        check("stop_busy4", 64'(busy), 64'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_grid", grid, 64'd0);
        check("stop_misc", 64'({prog_idx, busy, gen_done, gen_count, stable, extinct}), 64'd0);

        // Leaving RUN while busy aborts without commit.
        program_grid(64'h0000_0000_3800_0000);
        state = ST_RUN; wrap_mode = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick();
        state = ST_PROGRAM; tick();
        check("abort_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gen_done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_grid", grid, 64'h0000_0000_3800_0000);

        // HOLD freezes a generation mid-way; it resumes with the same result.
        rg = {$urandom(), $urandom()};
        program_grid(rg);
        state = ST_RUN; wrap_mode = 1'b1;
        exp_q.push_back(life_model(rg, 1'b1));
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick();
        state = ST_HOLD;
        for (int i = 0; i < 5; i++) tick();
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_done", 64'(gen_done), 64'd0);
        check("hold_grid", grid, rg);
        state = ST_RUN;
        cnt = 0;
        while (!gen_done && cnt < 40) begin
            tick();
            cnt++;
        end
        check("hold_latency", 64'(cnt), 64'd6);
        tick();
        check("hold_result", grid, exp_q.pop_front());
        check("hold_count", 64'(gen_count), 64'd1);

        // Saturating counter on a 2-bit instance sharing the same inputs.
        program_grid(64'h0000_0000_0000_0303);
        for (int i = 0; i < 5; i++) run_gen(1'b0, "sat");
        check("sat_main", 64'(gen_count), 64'd5);
        check("sat_g2", 64'(g2_cnt), 64'd3);
        check("sat_g2_grid", g2_grid, 64'h0000_0000_0000_0303);

        // 5x6 torus glider: shifts (+1,+1) every 4 generations, home after 120.
        g0 = 30'h0000_7102;
        g4 = 30'h0038_8100;
        s5_state = ST_IDLE; tick();
        s5_state = ST_PROGRAM;
        for (int i = 0; i < 30; i++) begin
            s5_b1 = g0[i];
            s5_b0 = ~g0[i];
            tick();
        end
        s5_b0 = 1'b0; s5_b1 = 1'b0;
        check("glider_prog", 64'(grid5), 64'(g0));
        s5_state = ST_RUN;
        lat_bad = 0;
        for (int gen = 1; gen <= 120; gen++) begin
            s5_step = 1'b1; tick(); s5_step = 1'b0;
            cnt = 0;
            while (!done5 && cnt < 20) begin
                tick();
                cnt++;
            end
            if (cnt != 5) lat_bad++;
            tick();
            if (gen == 4) check("glider_gen4", 64'(grid5), 64'(g4));
        end
        check("glider_latency", 64'(lat_bad), 64'd0);
        check("glider_home", 64'(grid5), 64'(g0));
        check("glider_count", 64'(cnt5), 64'd120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
